// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared state type, funct3 codes and MMIO addresses for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] ADDR_LEDS   = 32'hFFFF_FFFC;
    localparam logic [31:0] ADDR_MILLIS = 32'hFFFF_FFF8;
    localparam logic [31:0] ADDR_MICROS = 32'hFFFF_FFF4;

endpackage

// File: rtl/lsu_req_check.sv
// rtl/lsu_req_check.sv - combinational request classifier; alignment rejection only with LSU_MISALIGN_CHECK_EN
module lsu_req_check
    import lsu_pkg::*;
(
    input  logic       store_i,
    input  logic [2:0] funct3_i,
    input  logic [1:0] addr_lsb_i,
    output logic       err_o
);

    logic illegal;
    logic misaligned;

    always_comb begin
        illegal = 1'b1;
        if (store_i) begin
            illegal = !(funct3_i inside {F3_B, F3_H, F3_W});
        end else begin
            illegal = !(funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end
    end

    // funct3[1:0] encodes the access size for both signed and unsigned loads
    assign misaligned = ((funct3_i[1:0] == 2'b01) && addr_lsb_i[0]) ||
                        ((funct3_i[1:0] == 2'b10) && (addr_lsb_i != 2'b00));

`ifdef LSU_MISALIGN_CHECK_EN
    assign err_o = illegal | misaligned;
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
    assign err_o = illegal;
`endif

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory bus initiator with a valid/ready response channel
// Alignment rejection is enabled by defining LSU_MISALIGN_CHECK_EN.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_store_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic [2:0]  mem_funct3_o,
    output logic        mem_wren_o,
    output logic [31:0] mem_address_o,
    output logic [31:0] mem_data_in_o,
    input  logic [31:0] mem_data_out_i
);

    lsu_state_t  state_q, state_d;
    logic        store_q, store_d;
    logic [2:0]  mem_funct3_q, mem_funct3_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_data_in_q, mem_data_in_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        req_err;

    lsu_req_check u_req_check (
        .store_i    (req_store_i),
        .funct3_i   (req_funct3_i),
        .addr_lsb_i (req_addr_i[1:0]),
        .err_o      (req_err)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            store_q       <= 1'b0;
            mem_funct3_q  <= F3_W;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            resp_rdata_q  <= '0;
            resp_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            store_q       <= store_d;
            mem_funct3_q  <= mem_funct3_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
        end
    end

    // Bus registers double as the request latches; rejected requests never touch them,
    // so the address seen by data_mem only moves for accesses that are really made.
    always_comb begin
        state_d       = state_q;
        store_d       = store_q;
        mem_funct3_d  = mem_funct3_q;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        resp_rdata_d  = resp_rdata_q;
        resp_err_d    = resp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    store_d = req_store_i;
                    if (req_err) begin
                        resp_err_d = 1'b1;
                        state_d    = RESP;
                    end else begin
                        mem_funct3_d  = req_funct3_i;
                        mem_address_d = req_addr_i;
                        mem_data_in_d = req_wdata_i;
                        state_d       = ISSUE;
                    end
                end
            end
            ISSUE: state_d = store_q ? RESP : WAIT;
            WAIT: begin
                resp_rdata_d = mem_data_out_i;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready_i) begin
                    resp_err_d   = 1'b0;
                    resp_rdata_d = '0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready_o   = (state_q == IDLE);
    assign resp_valid_o  = (state_q == RESP);
    assign resp_rdata_o  = resp_rdata_q;
    assign resp_err_o    = resp_err_q;
    assign mem_wren_o    = (state_q == ISSUE) && store_q;
    assign mem_funct3_o  = mem_funct3_q;
    assign mem_address_o = mem_address_q;
    assign mem_data_in_o = mem_data_in_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a behavioural data_mem
module tb_load_store_unit;
    import lsu_pkg::*;

    typedef struct {
        logic        st;
        logic        err;
        logic        chk;
        logic [31:0] rdata;
        int          lat;
        int          acc_cyc;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_store_i = 1'b0;
    logic [2:0]  req_funct3_i = 3'b010;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b1;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic [2:0]  mem_funct3_o;
    logic        mem_wren_o;
    logic [31:0] mem_address_o;
    logic [31:0] mem_data_in_o;
    logic [31:0] dm_out = '0;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          wren_cnt = 0;
    logic        prev_valid = 1'b0;
    logic        bp_hold = 1'b0;
    logic [31:0] held_rdata = '0;
    logic        held_err = 1'b0;
    logic [31:0] last_rdata = '0;
    logic [31:0] last_bus_addr = '0;
    exp_t        sb_q[$];
    exp_t        mon_e;

    logic [31:0] ram_w [0:255];
    logic [7:0]  ref_mem [0:1023];
    logic [31:0] leds = '0;
    logic [31:0] ref_leds = '0;
    logic [31:0] millis = '0;
    logic [31:0] micros = '0;
    int          pre_us = 0;
    int          pre_ms = 0;
    logic [31:0] dm_w;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    load_store_unit dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_store_i    (req_store_i),
        .req_funct3_i   (req_funct3_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .resp_valid_o   (resp_valid_o),
        .resp_ready_i   (resp_ready_i),
        .resp_rdata_o   (resp_rdata_o),
        .resp_err_o     (resp_err_o),
        .mem_funct3_o   (mem_funct3_o),
        .mem_wren_o     (mem_wren_o),
        .mem_address_o  (mem_address_o),
        .mem_data_in_o  (mem_data_in_o),
        .mem_data_out_i (dm_out)
    );

    function automatic logic [31:0] dm_read(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        if (a == ADDR_LEDS)        w = leds;
        else if (a == ADDR_MILLIS) w = millis;
        else if (a == ADDR_MICROS) w = micros;
        else                       w = ram_w[a[9:2]];
        b = w[8*a[1:0] +: 8];
        h = w[16*a[1] +: 16];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // Stand-in for data_mem: synchronous write and one-cycle registered read, 12 MHz timers
    always @(posedge clk_i) begin
        if (pre_us == 11) begin pre_us <= 0; micros <= micros + 1; end
        else pre_us <= pre_us + 1;
        if (pre_ms == 11999) begin pre_ms <= 0; millis <= millis + 1; end
        else pre_ms <= pre_ms + 1;
        if (mem_wren_o) begin
            if (mem_address_o == ADDR_LEDS) begin
                leds <= mem_data_in_o;
            end else begin
                dm_w = ram_w[mem_address_o[9:2]];
                case (mem_funct3_o[1:0])
                    2'b00:   dm_w[8*mem_address_o[1:0] +: 8] = mem_data_in_o[7:0];
                    2'b01:   dm_w[16*mem_address_o[1] +: 16] = mem_data_in_o[15:0];
                    default: dm_w = mem_data_in_o;
                endcase
                ram_w[mem_address_o[9:2]] <= dm_w;
            end
        end
        dm_out <= dm_read(mem_address_o, mem_funct3_o);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: byte-addressed memory, access size 2^funct3[1:0], aligned down to that size
    function automatic exp_t model(input logic st, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        int          n;
        logic [31:0] base;
        logic [31:0] v;
        n       = 1 << f3[1:0];
        e.st    = st;
        e.chk   = 1'b1;
        e.rdata = '0;
        e.acc_cyc = 0;
        e.err   = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
`ifdef LSU_MISALIGN_CHECK_EN
        if (!e.err && (a % n) != 0) e.err = 1'b1;
`endif
        e.lat = e.err ? 1 : (st ? 2 : 3);
        if (!e.err) begin
            base = a - (a % n);
            if (a == ADDR_MILLIS || a == ADDR_MICROS) begin
                if (!st) e.chk = 1'b0;
            end else if (a == ADDR_LEDS) begin
                if (st) ref_leds = d;
                else    e.rdata = ref_leds;
            end else if (st) begin
                for (int j = 0; j < n; j++) ref_mem[10'(base + 32'(j))] = 8'(d >> (8*j));
            end else begin
                v = '0;
                for (int j = 0; j < n; j++) v = v | (32'(ref_mem[10'(base + 32'(j))]) << (8*j));
                if (!f3[2] && n < 4) v = 32'($signed(v << (32 - 8*n)) >>> (32 - 8*n));
                e.rdata = v;
            end
        end
        return e;
    endfunction

    // Monitor: pops the scoreboard when a new response appears, checks stability while held
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            prev_valid = 1'b0;
            wren_cnt   = 0;
        end else begin
            if (mem_wren_o) wren_cnt++;
            if (resp_valid_o && !prev_valid) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_resp: got rdata %h err %b with no request pending", resp_rdata_o, resp_err_o);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("resp_err", 32'(resp_err_o), 32'(mon_e.err));
                    if (mon_e.chk) check("resp_rdata", resp_rdata_o, mon_e.rdata);
                    check("resp_latency", 32'(cyc - mon_e.acc_cyc), 32'(mon_e.lat));
                    check("wren_cycles", 32'(wren_cnt), 32'(mon_e.st && !mon_e.err));
                end
                wren_cnt   = 0;
                held_rdata = resp_rdata_o;
                held_err   = resp_err_o;
                last_rdata = resp_rdata_o;
            end else if (resp_valid_o) begin
                check("held_rdata", resp_rdata_o, held_rdata);
                check("held_err", 32'(resp_err_o), 32'(held_err));
                check("held_req_ready", 32'(req_ready_o), 32'd0);
            end
            prev_valid   = resp_valid_o;
            resp_ready_i = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   n = 0;
        req_store_i  = st;
        req_funct3_i = f3;
        req_addr_i   = a;
        req_wdata_i  = d;
        req_valid_i  = 1'b1;
        while (!req_ready_o && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        if (!req_ready_o) begin
            check("accept_timeout", 32'(req_ready_o), 32'd1);
            req_valid_i = 1'b0;
            return;
        end
        e = model(st, f3, a, d);
        e.acc_cyc = cyc;
        if (!e.err) last_bus_addr = a;
        sb_q.push_back(e);
        @(negedge clk_i);
        req_valid_i  = 1'b0;
        req_addr_i   = $urandom;
        req_wdata_i  = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb_q.size() != 0 || resp_valid_o || !req_ready_o) && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        check("idle_reached", 32'(sb_q.size() == 0 && req_ready_o), 32'd1);
        check("bus_addr_hold", mem_address_o, last_bus_addr);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready_o), 32'd1);
        check({tag, "_resp_valid"}, 32'(resp_valid_o), 32'd0);
        check({tag, "_resp_rdata"}, resp_rdata_o, 32'd0);
        check({tag, "_resp_err"}, 32'(resp_err_o), 32'd0);
        check({tag, "_mem_wren"}, 32'(mem_wren_o), 32'd0);
        check({tag, "_mem_address"}, mem_address_o, 32'd0);
        check({tag, "_mem_funct3"}, 32'(mem_funct3_o), 32'd2);
        check({tag, "_mem_data_in"}, mem_data_in_o, 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] m1, m2, u1, u2;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        int          n;
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            ram_w[i] = w;
            for (int j = 0; j < 4; j++) ref_mem[4*i + j] = 8'(w >> (8*j));
        end
        #12;
        check_reset_vals("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        send(1'b1, F3_W, 32'h100, 32'hDEAD_BEEF);
        send(1'b0, F3_W, 32'h100, 32'h0);
        send(1'b0, F3_B, 32'h103, 32'h0);
        send(1'b0, F3_BU, 32'h103, 32'h0);
        send(1'b0, F3_HU, 32'h102, 32'h0);
        send(1'b0, F3_H, 32'h100, 32'h0);
        wait_idle();

        send(1'b1, F3_W, ADDR_LEDS, 32'h8040_2010);
        send(1'b0, F3_W, ADDR_LEDS, 32'h0);
        wait_idle();

        send(1'b0, F3_W, ADDR_MILLIS, 32'h0); wait_idle(); m1 = last_rdata;
        send(1'b0, F3_W, ADDR_MICROS, 32'h0); wait_idle(); u1 = last_rdata;
        repeat (2000) @(negedge clk_i);
        send(1'b0, F3_W, ADDR_MILLIS, 32'h0); wait_idle(); m2 = last_rdata;
        send(1'b0, F3_W, ADDR_MICROS, 32'h0); wait_idle(); u2 = last_rdata;
        check("millis_monotonic", 32'($signed(m2 - m1) >= 0), 32'd1);
        check("micros_advance", 32'((u2 - u1) >= 32'd166), 32'd1);

        send(1'b0, F3_W, 32'h101, 32'h0);
        send(1'b1, 3'b110, 32'h300, 32'h1234_5678);
        send(1'b1, 3'b011, 32'h304, 32'h1234_5678);
        send(1'b0, 3'b111, 32'h308, 32'h0);
        wait_idle();

        bp_hold = 1'b1;
        send(1'b0, F3_W, 32'h100, 32'h0);
        n = 0;
        while (!resp_valid_o && n < 20) begin @(negedge clk_i); n++; end
        check("bp_resp_seen", 32'(resp_valid_o), 32'd1);
        repeat (5) begin
            @(negedge clk_i);
            check("bp_resp_valid", 32'(resp_valid_o), 32'd1);
            check("bp_req_ready", 32'(req_ready_o), 32'd0);
        end
        bp_hold = 1'b0;
        wait_idle();

        send(1'b0, F3_W, 32'h200, 32'h0);
        @(negedge clk_i);
        check("wait_mem_address", mem_address_o, 32'h200);
        rst_ni = 1'b0;
        #1;
        check_reset_vals("midreset");
        sb_q.delete();
        last_bus_addr = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("post_reset_idle", 32'(req_ready_o), 32'd1);

        for (int k = 0; k < 300; k++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 15) == 0) begin
                f3 = F3_W;
                a  = ADDR_LEDS;
            end
            send(st, f3, a, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end
        wait_idle();
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
